// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and
// serialises it as start bit, LSB-first data, optional parity and
// one or two stop bits, with an internal bit-period counter.
module uart_tx #(
  parameter int CLKS_PER_BIT = 2083,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  // Counter must hold 0..CLKS_PER_BIT-1; guard the width for degenerate values.
  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

  // Parameter sanity checks, reported at elaboration.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_reg,  state_next;
  logic [CNT_W-1:0]     cnt_reg,    cnt_next;
  logic [2:0]           idx_reg,    idx_next;
  logic [DATA_BITS-1:0] shift_reg,  shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg,     tx_next;
  logic                 done_reg,   done_next;
  logic                 bit_end;

  assign bit_end = (cnt_reg == CNT_MAX);

  // State, counters and the registered line; reset forces an idle-high line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic; the line value is derived from the state being entered
  // so tx changes on the same edge as the state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;
    tx_next     = 1'b1;

    if (state_reg != S_IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          state_next  = S_START;
          shift_next  = tx_data;
          parity_next = (^tx_data) ^ (PARITY_ODD != 0);
          cnt_next    = '0;
          idx_next    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          idx_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (idx_reg == LAST_DATA) begin
            idx_next   = '0;
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          idx_next   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_reg == LAST_STOP) begin
            state_next = S_IDLE;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_next;
      default:  tx_next = 1'b1;
    endcase
  end

  assign tx       = tx_reg;
  assign tx_done  = done_reg;
  assign tx_ready = (state_reg == S_IDLE);
  assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (8N1, 8E2, 8O2) at
// CLKS_PER_BIT=4, checked against a frame model built from bit positions.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .tx_busy(bsy0), .tx_done(dn0), .tx(tx0));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .tx_busy(bsy1), .tx_done(dn1), .tx(tx1));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rstn(rstn), .tx_valid(v2), .tx_data(d2),
    .tx_ready(rdy2), .tx_busy(bsy2), .tx_done(dn2), .tx(tx2));

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx0 : (w == 1) ? tx1 : tx2;
  endfunction
  function automatic logic get_rdy(input int w);
    return (w == 0) ? rdy0 : (w == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic get_bsy(input int w);
    return (w == 0) ? bsy0 : (w == 1) ? bsy1 : bsy2;
  endfunction
  function automatic logic get_dn(input int w);
    return (w == 0) ? dn0 : (w == 1) ? dn1 : dn2;
  endfunction

  task automatic set_in(input int w, input logic valid, input logic [7:0] data);
    case (w)
      0: begin v0 = valid; d0 = data; end
      1: begin v1 = valid; d1 = data; end
      default: begin v2 = valid; d2 = data; end
    endcase
  endtask

  // Reference: line level for bit slot p of a frame.
  function automatic logic frame_bit(input logic [7:0] data, input int pen, input int podd, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return logic'((data >> (p - 1)) & 8'h01);
    if (pen != 0 && p == 9) return logic'(($countones(data) + podd) % 2);
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on instance w; checks every cycle, decodes data and parity mid-bit.
  task automatic run_frame(input int w, input logic [7:0] data, input int pen, input int podd,
                           input int sb, input bit noisy, output logic [7:0] dec, output logic pbit);
    int len;
    len = (1 + 8 + pen + sb) * CPB;
    dec = '0;
    pbit = 1'b0;
    @(negedge clk);
    chk("ready_before_send", 32'(get_rdy(w)), 32'd1);
    set_in(w, 1'b1, data);
    @(posedge clk);
    #1 set_in(w, 1'b0, noisy ? 8'($urandom) : data);
    for (int t = 0; t <= len + 1; t++) begin
      @(negedge clk);
      chk("frame_tx", 32'(get_tx(w)), 32'((t < len) ? frame_bit(data, pen, podd, t / CPB) : 1'b1));
      chk("frame_ready", 32'(get_rdy(w)), 32'(t >= len));
      chk("frame_busy", 32'(get_bsy(w)), 32'(t < len));
      chk("frame_done", 32'(get_dn(w)), 32'(t == len));
      for (int k = 0; k < 8; k++)
        if (t == (1 + k) * CPB + CPB / 2) dec[k] = get_tx(w);
      if (t == 9 * CPB + CPB / 2) pbit = get_tx(w);
      if (noisy) set_in(w, (t == len / 2), 8'($urandom));
    end
    $display("frame dut%0d data=%02h decoded=%02h parity_sample=%0d", w, data, dec, pbit);
  endtask

  logic [7:0] dec, a, b;
  logic pbit;
  int dones;

  initial begin
    // Reset then 100 idle cycles on every instance.
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_ready", 32'(rdy0), 32'd1);
    rstn = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
        chk("idle_tx", 32'(get_tx(w)), 32'd1);
        chk("idle_ready", 32'(get_rdy(w)), 32'd1);
        chk("idle_busy", 32'(get_bsy(w)), 32'd0);
        chk("idle_done", 32'(get_dn(w)), 32'd0);
      end
    end
    $display("idle check done after 100 cycles");

    // 8N1 single byte 0x55.
    run_frame(0, 8'h55, 0, 0, 1, 1'b0, dec, pbit);
    chk("decode_55", 32'(dec), 32'h55);

    // Even / odd parity with two stop bits, 0x07.
    run_frame(1, 8'h07, 1, 0, 2, 1'b0, dec, pbit);
    chk("decode_even_07", 32'(dec), 32'h07);
    chk("parity_even_07", 32'(pbit), 32'd1);
    run_frame(2, 8'h07, 1, 1, 2, 1'b0, dec, pbit);
    chk("decode_odd_07", 32'(dec), 32'h07);
    chk("parity_odd_07", 32'(pbit), 32'd0);

    // Data churn and a stray valid pulse during a 0x55 frame.
    run_frame(0, 8'h55, 0, 0, 1, 1'b1, dec, pbit);
    chk("decode_noisy_55", 32'(dec), 32'h55);
    set_in(0, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("no_extra_frame_tx", 32'(tx0), 32'd1);
      chk("no_extra_frame_ready", 32'(rdy0), 32'd1);
    end

    // Back-to-back 0xA5 then 0x3C with valid held high.
    dones = 0;
    a = '0;
    b = '0;
    @(negedge clk);
    set_in(0, 1'b1, 8'hA5);
    @(posedge clk);
    #1 set_in(0, 1'b1, 8'h3C);
    for (int t = 0; t <= 83; t++) begin
      logic e;
      @(negedge clk);
      if (t < 40) e = frame_bit(8'hA5, 0, 0, t / CPB);
      else if (t >= 41 && t < 81) e = frame_bit(8'h3C, 0, 0, (t - 41) / CPB);
      else e = 1'b1;
      chk("b2b_tx", 32'(tx0), 32'(e));
      if (t == 40) chk("b2b_ready_gap", 32'(rdy0), 32'd1);
      if (dn0) dones++;
      for (int k = 0; k < 8; k++) begin
        if (t == (1 + k) * CPB + 2) a[k] = tx0;
        if (t == 41 + (1 + k) * CPB + 2) b[k] = tx0;
      end
      if (t == 41) set_in(0, 1'b0, 8'h00);
    end
    chk("b2b_first", 32'(a), 32'hA5);
    chk("b2b_second", 32'(b), 32'h3C);
    chk("b2b_done_count", 32'(dones), 32'd2);
    $display("back-to-back decoded=%02h,%02h dones=%0d", a, b, dones);

    // Reset during data bit 3 of a random frame.
    @(negedge clk);
    set_in(0, 1'b1, 8'($urandom));
    @(posedge clk);
    #1 set_in(0, 1'b0, 8'h00);
    repeat (18) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx0), 32'd1);
    chk("midreset_ready", 32'(rdy0), 32'd1);
    chk("midreset_busy", 32'(bsy0), 32'd0);
    chk("midreset_done", 32'(dn0), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dn0) dones++;
      chk("post_reset_tx", 32'(tx0), 32'd1);
    end
    chk("post_reset_no_done", 32'(dones), 32'd0);
    $display("mid-frame reset recovered");

    // Randomised frames on all three configurations.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      run_frame(0, r, 0, 0, 1, 1'b0, dec, pbit);
      chk("rand_8n1", 32'(dec), 32'(r));
      r = 8'($urandom);
      run_frame(1, r, 1, 0, 2, 1'b0, dec, pbit);
      chk("rand_8e2", 32'(dec), 32'(r));
      chk("rand_8e2_parity", 32'(pbit), 32'($countones(r) % 2));
      r = 8'($urandom);
      run_frame(2, r, 1, 1, 2, 1'b0, dec, pbit);
      chk("rand_8o2", 32'(dec), 32'(r));
      chk("rand_8o2_parity", 32'(pbit), 32'(($countones(r) + 1) % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
